layer_in_buf: RTL and testbench

Serial-to-parallel activation buffer that sits directly upstream of the combinational fully-connected `layer` stage. It accepts one WIDTH-bit activation per handshake, assembles IN of them into a register array, and presents the whole vector on `x[0:IN-1]` with a valid flag. The vector is held stable until the downstream consumer takes it. Because the layer is purely combinational, its output `z` is valid whenever `x_valid` is high.

---
 rtl/layer_in_buf.sv | 105 ++++++++++
 tb/tb_layer_in_buf.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/layer_in_buf.sv
// Serial-to-parallel activation buffer feeding the combinational layer.
// Optional framing check on s_last: define LAYER_IN_BUF_LAST_CHECK_EN.
module layer_in_buf #(
  parameter int WIDTH = 8,
  parameter int IN    = 84
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic [WIDTH-1:0] x [0:IN-1],
  output logic             x_valid,
  input  logic             x_ready,
  output logic             err,
  output logic [15:0]      vec_cnt
);

  localparam int IW = (IN > 1) ? $clog2(IN) : 1;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             err_q, err_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q [0:IN-1];

  logic beat;
  logic at_end;
  logic early;
  logic miss;

  assign s_ready = (state_q == FILL) & ~rst;
  assign x_valid = (state_q == HOLD);
  assign beat    = s_valid & s_ready;
  assign at_end  = (idx_q == IW'(IN - 1));

`ifdef LAYER_IN_BUF_LAST_CHECK_EN
  assign early = beat & s_last & ~at_end;
  assign miss  = beat & at_end & ~s_last;
`else
  logic last_unused;
  assign last_unused = s_last;
  assign early = 1'b0;
  assign miss  = 1'b0;
`endif

  // Next-state for the fill/hold sequencer and its counters.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (1'b1)
      (state_q == FILL): begin
        if (beat) begin
          if (early) begin
            idx_d = '0;
            err_d = 1'b1;
          end else if (at_end) begin
            idx_d   = '0;
            state_d = HOLD;
            if (miss) err_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      (state_q == HOLD): begin
        if (x_ready) begin
          state_d = FILL;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  // State, counters and the vector registers; reset wins over handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      idx_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      for (int k = 0; k < IN; k++) x_q[k] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      if (beat) x_q[idx_q] <= s_data;
    end
  end

  assign x       = x_q;
  assign err     = err_q;
  assign vec_cnt = cnt_q;

endmodule

// File: tb/tb_layer_in_buf.sv
// Scoreboard bench for layer_in_buf.
// Framing tests depend on LAYER_IN_BUF_LAST_CHECK_EN.
module tb_layer_in_buf;

  localparam int WIDTH = 8;
  localparam int IN    = 84;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid = 1'b0;
  logic             s_last = 1'b0;
  logic             x_ready = 1'b0;
  logic [WIDTH-1:0] s_data = '0;
  logic             s_ready;
  logic             x_valid;
  logic             err;
  logic [WIDTH-1:0] x [0:IN-1];
  logic [15:0]      vec_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [IN*8-1:0] d;
    logic            e;
    logic [15:0]     c;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  logic [15:0] exp_cnt = '0;
  logic        exp_err = 1'b0;
  logic        xv_prev = 1'b0;

  always #5 clk = ~clk;

  layer_in_buf #(.WIDTH(WIDTH), .IN(IN)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_last  (s_last),
    .x       (x),
    .x_valid (x_valid),
    .x_ready (x_ready),
    .err     (err),
    .vec_cnt (vec_cnt)
  );

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic chkv(input string n, input logic [IN*8-1:0] e);
    int bad;
    bad = -1;
    checks++;
    for (int k = 0; k < IN; k++)
      if (bad < 0 && x[k] !== e[k*8 +: 8]) bad = k;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: x[%0d] got %0h expected %0h",
               n, bad, x[bad], e[bad*8 +: 8]);
    end
  endtask

  function automatic logic [IN*8-1:0] fillv(input logic [7:0] v);
    logic [IN*8-1:0] r;
    for (int k = 0; k < IN; k++) r[k*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [IN*8-1:0] rampv();
    logic [IN*8-1:0] r;
    for (int k = 0; k < IN; k++) r[k*8 +: 8] = 8'(k + 1);
    return r;
  endfunction

  always @(negedge clk) begin
    if (x_valid === 1'b1 && !xv_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vector: got x_valid 1 expected none");
      end else begin
        me = sb.pop_front();
        chkv("mon_data", me.d);
        chk("mon_err", 32'(err), 32'(me.e));
        chk("mon_cnt", 32'(vec_cnt), 32'(me.c));
      end
    end
    xv_prev <= (x_valid === 1'b1);
  end

  task automatic beat(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (s_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: got s_ready %b expected 1", s_ready);
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_vec(input logic [IN*8-1:0] v, input int last_at,
                          input bit gaps, input string n);
    for (int k = 0; k < IN; k++) begin
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      if (k == IN - 1) chk({n, "_pre_valid"}, 32'(x_valid), 0);
      beat(v[k*8 +: 8], k == last_at);
    end
    chk({n, "_valid_rise"}, 32'(x_valid), 1);
    chk({n, "_sready_hold"}, 32'(s_ready), 0);
  endtask

  task automatic consume(input string n);
    chk({n, "_valid_before"}, 32'(x_valid), 1);
    x_ready = 1'b1;
    @(negedge clk);
    x_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    chk({n, "_valid_fall"}, 32'(x_valid), 0);
    chk({n, "_sready_back"}, 32'(s_ready), 1);
    chk({n, "_vec_cnt"}, 32'(vec_cnt), 32'(exp_cnt));
  endtask

  task automatic do_reset(input int n);
    rst     = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    x_ready = 1'b0;
    repeat (n) begin
      @(negedge clk);
      chk("rst_sready", 32'(s_ready), 0);
      chk("rst_xvalid", 32'(x_valid), 0);
    end
    rst = 1'b0;
    #1;
    chk("rst_sready_after", 32'(s_ready), 1);
    chk("rst_err", 32'(err), 0);
    chk("rst_vec_cnt", 32'(vec_cnt), 0);
    chkv("rst_x_zero", fillv(8'h00));
    exp_cnt = '0;
    exp_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    do_reset(3);
    for (int k = 0; k < 10; k++) beat(8'h55, 1'b0);
    do_reset(3);

    sb.push_back('{d: rampv(), e: exp_err, c: exp_cnt});
    send_vec(rampv(), IN - 1, 1'b0, "fill");
    chkv("fill_data", rampv());
    s_valid = 1'b1;
    repeat (20) begin
      s_data = 8'($urandom);
      s_last = 1'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(x_valid), 1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chkv("hold_stable", rampv());
    consume("c1");

    sb.push_back('{d: fillv(8'hA5), e: exp_err, c: exp_cnt});
    send_vec(fillv(8'hA5), IN - 1, 1'b1, "a5");
    repeat (3) @(negedge clk);
    consume("c2");
    chk("vec_cnt_two", 32'(vec_cnt), 2);

`ifdef LAYER_IN_BUF_LAST_CHECK_EN
    for (int k = 0; k < 40; k++) beat(8'h11, 1'b0);
    beat(8'h11, 1'b1);
    exp_err = 1'b1;
    chk("early_err", 32'(err), 1);
    chk("early_no_valid", 32'(x_valid), 0);
    repeat (3) @(negedge clk);
    chk("early_no_valid_later", 32'(x_valid), 0);
    sb.push_back('{d: fillv(8'h07), e: 1'b1, c: exp_cnt});
    send_vec(fillv(8'h07), IN - 1, 1'b0, "after_early");
    chk("early_err_sticky", 32'(err), 1);
    consume("c3");
    do_reset(2);
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    sb.push_back('{d: fillv(8'h3C), e: exp_err, c: exp_cnt});
    send_vec(fillv(8'h3C), -1, 1'b0, "nolast");
    chk("nolast_err", 32'(err), 32'(exp_err));
    consume("c4");

    for (int k = 0; k < 50; k++) beat(8'h99, 1'b0);
    do_reset(1);
    sb.push_back('{d: fillv(8'h03), e: 1'b0, c: exp_cnt});
    send_vec(fillv(8'h03), IN - 1, 1'b0, "post_rst");
    chkv("post_rst_data", fillv(8'h03));
    consume("c5");

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
